// File: rtl/bagging_feeder.sv
// bagging_feeder: buffers one serial feature vector, then runs each base learner in turn
// (start pulse, N_FEAT feature/weight beats with the bias held, result capture) and hands
// the collected decision vector to the vote stage.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   cfg_*               weight/bias write port, accepted only while cfg_ready (LOAD)
//   s_valid/ready/data/last  serial feature input
//   en, data, weight, bias, lr_sel  learner drive; lr_ready, lr_result  learner answer
//   out_valid/ready/results  decision vector to the vote stage
//   err                 sticky watchdog flag (FEEDER_TIMEOUT_EN), otherwise tied to 0
// Optional feature macro: FEEDER_TIMEOUT_EN enables the WAIT-state watchdog.
module bagging_feeder #(
    parameter int N_FEAT  = 30,
    parameter int N_LEARN = 3,
    parameter int AW      = 5,
    parameter int LW      = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic                 cfg_bias_we,
    input  logic [LW-1:0]        cfg_learner,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [8:0]           cfg_wdata,
    output logic                 cfg_ready,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [1:0]           s_data,
    input  logic                 s_last,
    output logic                 en,
    output logic [1:0]           data,
    output logic [8:0]           weight,
    output logic [8:0]           bias,
    output logic [LW-1:0]        lr_sel,
    input  logic                 lr_ready,
    input  logic [1:0]           lr_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N_LEARN-1:0] out_results,
    output logic                 err
);
    typedef enum logic [2:0] {LOAD, FIRE, STREAM, WAIT, DONE} state_t;
    state_t               state_q;
    logic [AW-1:0]        cnt_q;
    logic [LW-1:0]        lr_sel_q;
    logic [1:0]           feat_q [N_FEAT];
    logic [8:0]           w_q [N_LEARN][N_FEAT];
    logic [8:0]           b_q [N_LEARN];
    logic                 s_ready_q, cfg_ready_q, en_q, out_valid_q;
    logic [1:0]           data_q;
    logic [8:0]           weight_q, bias_q;
    logic [2*N_LEARN-1:0] res_q;
    logic                 accept, load_done, cfg_ok, timeout, answered;
    logic [1:0]           answer;

    assign accept    = s_valid && s_ready_q;
    assign load_done = accept && (s_last || cnt_q == AW'(N_FEAT - 1));
    assign cfg_ok    = cfg_ready_q && ({1'b0, cfg_learner} < (LW + 1)'(N_LEARN))
                                   && ({1'b0, cfg_addr} < (AW + 1)'(N_FEAT));
    // A watchdog expiry advances the sequence exactly like an answer of 2'b00.
    assign answered  = lr_ready || timeout;
    assign answer    = lr_ready ? lr_result : 2'b00;

`ifdef FEEDER_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       err_q;
    // wd_q counts completed WAIT cycles; 254 means this edge closes the 255th.
    assign timeout = !lr_ready && wd_q == 8'd254;
    assign err     = err_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q <= (state_q == WAIT && !lr_ready) ? wd_q + 8'd1 : 8'd0;
            if (state_q == WAIT && timeout) err_q <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            lr_sel_q    <= '0;
            s_ready_q   <= 1'b0;
            cfg_ready_q <= 1'b0;
            en_q        <= 1'b0;
            data_q      <= '0;
            weight_q    <= '0;
            bias_q      <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            for (int i = 0; i < N_FEAT; i++) feat_q[i] <= '0;
            for (int k = 0; k < N_LEARN; k++) begin
                b_q[k] <= '0;
                for (int i = 0; i < N_FEAT; i++) w_q[k][i] <= '0;
            end
        end else begin
            if (cfg_ok && cfg_bias_we) b_q[cfg_learner] <= cfg_wdata;
            else if (cfg_ok && cfg_we) w_q[cfg_learner][cfg_addr] <= cfg_wdata;
            case (state_q)
                LOAD: begin
                    s_ready_q   <= !load_done;
                    cfg_ready_q <= !load_done;
                    // Write the accepted beat; an early s_last zero-fills the tail.
                    for (int i = 0; i < N_FEAT; i++)
                        if (accept && AW'(i) == cnt_q) feat_q[i] <= s_data;
                        else if (load_done && AW'(i) > cnt_q) feat_q[i] <= '0;
                    if (accept) cnt_q <= cnt_q + 1'b1;
                    if (load_done) begin
                        state_q  <= FIRE;
                        cnt_q    <= '0;
                        lr_sel_q <= '0;
                        en_q     <= 1'b1;
                        bias_q   <= b_q[0];
                    end
                end
                FIRE: begin
                    en_q     <= 1'b0;
                    data_q   <= feat_q[0];
                    weight_q <= w_q[lr_sel_q][0];
                    cnt_q    <= '0;
                    state_q  <= STREAM;
                end
                STREAM: begin
                    // cnt_q is the index of the beat currently on the outputs.
                    if (cnt_q == AW'(N_FEAT - 1)) begin
                        data_q   <= '0;
                        weight_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= WAIT;
                    end else begin
                        data_q   <= feat_q[cnt_q + 1'b1];
                        weight_q <= w_q[lr_sel_q][cnt_q + 1'b1];
                        cnt_q    <= cnt_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (answered) begin
                        res_q[2*lr_sel_q +: 2] <= answer;
                        if (lr_sel_q == LW'(N_LEARN - 1)) begin
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            lr_sel_q <= lr_sel_q + 1'b1;
                            bias_q   <= b_q[lr_sel_q + 1'b1];
                            en_q     <= 1'b1;
                            state_q  <= FIRE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                        cfg_ready_q <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign s_ready     = s_ready_q;
    assign cfg_ready   = cfg_ready_q;
    assign en          = en_q;
    assign data        = data_q;
    assign weight      = weight_q;
    assign bias        = bias_q;
    assign lr_sel      = lr_sel_q;
    assign out_valid   = out_valid_q;
    assign out_results = res_q;
endmodule

// File: tb/tb_bagging_feeder.sv
// tb_bagging_feeder: randomized self-checking bench for bagging_feeder against a
// behavioural model of the weight/bias tables, feature vector and learner timeline.
module tb_bagging_feeder;
    localparam int NF = 30;
    localparam int NL = 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       cfg_we = 1'b0, cfg_bias_we = 1'b0;
    logic [1:0] cfg_learner = '0;
    logic [4:0] cfg_addr = '0;
    logic [8:0] cfg_wdata = '0;
    logic       cfg_ready;
    logic       s_valid = 1'b0, s_last = 1'b0, s_ready;
    logic [1:0] s_data = '0;
    logic       en;
    logic [1:0] data;
    logic [8:0] weight, bias;
    logic [1:0] lr_sel;
    logic       lr_ready = 1'b0;
    logic [1:0] lr_result = '0;
    logic       out_valid, out_ready = 1'b0, err;
    logic [5:0] out_results;

    bagging_feeder dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_bias_we(cfg_bias_we),
        .cfg_learner(cfg_learner), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_ready(cfg_ready), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .en(en), .data(data), .weight(weight), .bias(bias),
        .lr_sel(lr_sel), .lr_ready(lr_ready), .lr_result(lr_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_results(out_results), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0, t0 = 0;
    int wm [NL][NF];
    int bm [NL];
    int fv [NF];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle();
        check("rst_en", en, 0);
        check("rst_data", data, 0);
        check("rst_weight", weight, 0);
        check("rst_bias", bias, 0);
        check("rst_lr_sel", lr_sel, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_results", out_results, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_cfg_ready", cfg_ready, 0);
        check("rst_err", err, 0);
    endtask

    task automatic cfg_write(input int l, input int a, input int v, input bit we, input bit bwe);
        @(negedge clk);
        check("cfg_ready", cfg_ready, 1);
        cfg_learner = 2'(l);
        cfg_addr    = 5'(a);
        cfg_wdata   = 9'(v);
        cfg_we      = we;
        cfg_bias_we = bwe;
        if (l < NL && a < NF) begin
            if (bwe) bm[l] = v;
            else if (we) wm[l][a] = v;
        end
        @(posedge clk);
        #1 cfg_we = 1'b0;
        cfg_bias_we = 1'b0;
    endtask

    // Sends nb beats (s_last on the final one); the model zero-fills the rest.
    task automatic load_feats(input int nb, input bit rnd);
        for (int i = 0; i < NF; i++) fv[i] = (i < nb) ? (rnd ? int'($urandom_range(0, 3)) - 2 : 1) : 0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            check("s_ready_load", s_ready, 1);
            s_valid = 1'b1;
            s_data  = 2'(fv[i]);
            s_last  = (i == nb - 1);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        t0 = cyc;
    endtask

    // Called at the negedge of the first en cycle; plays every learner answering
    // after w WAIT cycles with the 2-bit slots of res (learner 2 silent if mute).
    task automatic run_learners(input int w, input logic [5:0] res, input int hold,
                                input bit scfg, input bit mute);
        logic [5:0] expv;
        int lat;
        expv = res;
        lat = 0;
        for (int k = 0; k < NL; k++) begin
            int wk;
            bit silent;
            silent = mute && k == NL - 1;
            wk = silent ? 255 : w;
            lat += 1 + NF + wk;
            if (silent) expv[2*k +: 2] = 2'b00;
            check("en_pulse", en, 1);
            check("fire_lr_sel", lr_sel, k);
            check("fire_bias", $signed(bias), bm[k]);
            check("busy_s_ready", s_ready, 0);
            for (int j = 0; j < NF; j++) begin
                @(negedge clk);
                check("stream_en", en, 0);
                check("stream_data", $signed(data), fv[j]);
                check("stream_weight", $signed(weight), wm[k][j]);
                check("stream_bias", $signed(bias), bm[k]);
                lr_ready  = 1'($urandom);
                lr_result = 2'($urandom);
                if (scfg && k == 0 && j == 3) begin
                    check("stream_cfg_ready", cfg_ready, 0);
                    cfg_learner = 2'd0;
                    cfg_addr    = 5'd0;
                    cfg_wdata   = 9'((wm[0][0] == 100) ? 101 : 100);
                    cfg_we      = 1'b1;
                end else begin
                    cfg_we = 1'b0;
                end
            end
            for (int c = 1; c <= wk; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    check("wait_data", data, 0);
                    check("wait_weight", weight, 0);
                end
                lr_ready  = (c == wk) && !silent;
                lr_result = res[2*k +: 2];
            end
            @(negedge clk);
            lr_ready = 1'($urandom);
        end
        lr_ready = 1'b0;
        check("out_latency", cyc - t0, lat);
        check("out_valid", out_valid, 1);
        check("out_results", out_results, expv);
        s_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", out_valid, 1);
            check("hold_results", out_results, expv);
            check("hold_s_ready", s_ready, 0);
        end
        s_valid   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_s_ready", s_ready, 1);
    endtask

    initial begin
        for (int k = 0; k < NL; k++) begin
            bm[k] = 0;
            for (int i = 0; i < NF; i++) wm[k][i] = 0;
        end
        repeat (3) @(negedge clk);
        check_idle();
        rst = 1'b1;
        @(negedge clk);
        check("first_s_ready", s_ready, 1);
        check("first_cfg_ready", cfg_ready, 1);
        for (int n = 0; n < 25; n++)
            cfg_write($urandom_range(0, 3), $urandom_range(0, 31), int'($urandom_range(0, 511)) - 256,
                      1'($urandom), 1'($urandom));
        cfg_write(1, 0, -3, 1'b1, 1'b0);
        cfg_write(1, 0, 5, 1'b1, 1'b1);
        cfg_write(1, 30, 77, 1'b0, 1'b1);
        cfg_write(3, 2, 44, 1'b1, 1'b0);
        load_feats(30, 1'b0);
        run_learners(2, 6'b011101, 5, 1'b0, 1'b0);
        load_feats(10, 1'b1);
        run_learners(3, 6'($urandom), 0, 1'b1, 1'b0);
        load_feats(30, 1'b1);
        run_learners(1, 6'($urandom), 2, 1'b0, 1'b0);
        load_feats(30, 1'b1);
        repeat (12) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_idle();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < NL; k++) begin
            bm[k] = 0;
            for (int i = 0; i < NF; i++) wm[k][i] = 0;
        end
        load_feats(30, 1'b1);
        run_learners(2, 6'($urandom), 1, 1'b0, 1'b0);
        cfg_write(2, 7, -100, 1'b1, 1'b0);
        cfg_write(0, 29, 200, 1'b1, 1'b0);
`ifdef FEEDER_TIMEOUT_EN
        load_feats(30, 1'b1);
        run_learners(1, 6'($urandom), 0, 1'b0, 1'b1);
        check("timeout_err", err, 1);
`else
        load_feats(25, 1'b1);
        run_learners(1, 6'($urandom), 0, 1'b0, 1'b0);
        check("err_tied", err, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bagging_feeder.md
# bagging_feeder

Upstream sequencer for the bagging classifier array. Buffers one serial feature vector, then, for each base learner in turn, pulses the learner's start, streams the feature/weight pairs one per cycle with that learner's bias held, and captures the learner's ±1 decision. When every learner has answered, it presents the collected decision vector to the downstream vote stage.

## Interface
- N_FEAT, 30: features per sample and beats per learner run.
- N_LEARN, 3: base learners served per sample.
- AW, 5: feature-address width; requires 2^AW ≥ N_FEAT.
- LW, 2: learner-index width; requires 2^LW ≥ N_LEARN.

- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cfg_we  in  1  weight write strobe.
- cfg_bias_we  in  1  bias write strobe.
- cfg_learner  in  LW  target learner.
- cfg_addr  in  AW  target feature index for weight writes.
- cfg_wdata  in  9  signed weight or bias value.
- cfg_ready  out  1  high when configuration writes are accepted.
- s_valid  in  1  feature beat valid.
- s_ready  out  1  feature beat accepted when s_valid && s_ready.
- s_data  in  2  signed feature.
- s_last  in  1  final feature of the sample.
- en  out  1  one-cycle learner start pulse.
- data  out  2  signed feature beat to the learner.
- weight  out  9  signed weight beat to the learner.
- bias  out  9  bias of the active learner, held for the whole run.
- lr_sel  out  LW  index of the active learner.
- lr_ready  in  1  active learner's result is valid.
- lr_result  in  2  active learner's decision: 2'b01 or 2'b11.
- out_valid  out  1  decision vector valid.
- out_ready  in  1  downstream accepts the vector.
- out_results  out  2*N_LEARN  decision vector; learner k occupies bits [2k+1:2k].
- err  out  1  sticky timeout flag; present only with the macro.

## Operation
- States: LOAD, FIRE, STREAM, WAIT, DONE.
- Reset: all registers, weights, biases and feature buffer are cleared.
  - Reset values: state LOAD, s_ready 0, cfg_ready 0, en 0, data 0, weight 0, bias 0, lr_sel 0, out_valid 0, out_results 0, err 0.
  - The first cycle after reset release has s_ready=1 and cfg_ready=1.
- LOAD:
  - s_ready=1 and cfg_ready=1.
  - An accepted beat writes feat[cnt] and increments cnt.
  - The state leaves LOAD when the beat is accepted with s_last=1 or is the N_FEAT-th beat. Features beyond an early s_last are zero-filled.
  - Exit clears cnt and lr_sel, and enters FIRE.
- Configuration writes:
  - Honoured only in LOAD; dropped silently in every other state.
  - A write with cfg_addr ≥ N_FEAT or cfg_learner ≥ N_LEARN is dropped.
  - When cfg_we and cfg_bias_we are both high, only the bias write occurs.
- FIRE: en=1 for exactly one cycle, bias=bias[lr_sel]; then STREAM.
- STREAM:
  - For idx=0..N_FEAT-1, data=feat[idx] and weight=w[lr_sel][idx] on consecutive cycles.
  - After the last beat, data and weight return to 0 and the state enters WAIT.
- WAIT:
  - On the first edge with lr_ready=1, lr_result is stored in slot lr_sel.
  - If lr_sel = N_LEARN-1 the state enters DONE; otherwise lr_sel increments and the state enters FIRE.
  - lr_result values other than 01 or 11 are stored unchanged.
- DONE:
  - out_valid=1 and out_results is stable until out_ready=1.
  - The handshake cycle clears out_valid and returns to LOAD.
  - The feature buffer is not cleared; weights persist across samples.

## Timing
- First data/weight beat appears the cycle after en is high. en is never asserted while the previous learner's run is in STREAM.
- Per learner: 1 FIRE cycle + N_FEAT STREAM cycles + W WAIT cycles, where W ≥ 1 is the learner's response time.
- Final s_last accept to out_valid, with all learners at response W: N_LEARN·(1+N_FEAT+W) cycles. With defaults and W=3 this is 102 cycles.
- A zero-wait DONE→LOAD handshake allows a new feature beat on the cycle after out_ready.
- lr_ready outside WAIT is ignored.
- Asynchronous reset mid-run immediately forces the reset values; any partial vector is discarded.

## Configuration
- FEEDER_TIMEOUT_EN defined:
  - WAIT runs an 8-bit watchdog. If lr_ready is still low after 255 WAIT cycles, slot lr_sel is written with 2'b00, err is set, and sequencing continues as if the learner had answered.
  - err is cleared only by reset.
- Undefined: no watchdog, WAIT holds indefinitely, and err is tied to 0.

## Test plan
- Reset then idle: every output reads 0; the first cycle after release has s_ready=1.
- Write w[1][0]=-3, bias[1]=5, then 30 features of +1 with the learner model answering W=2:
  - en pulses 3 times.
  - During learner 1: weight=-3 on its first beat and bias=5 for the whole run.
  - out_valid rises after 3·33=99 cycles.
- s_last on beat 10: features 10..29 stream as 0, and each learner run is still 30 beats.
- Learners answer 01, 11, 01: out_results=6'b011101. Holding out_ready=0 for 5 cycles keeps the vector stable, and s_ready stays 0 until the handshake.
- cfg_we pulsed during STREAM: the stored weight is unchanged on the next sample.
- With FEEDER_TIMEOUT_EN, learner 2 never answers: the slot becomes 00, err=1, and out_valid still rises.
